// File: rtl/clint_pkg.sv
// Shared definitions for the machine-mode interrupt/exception controller:
// one-hot sequencer states, CSR addresses and the trap-related opcodes.
package clint_pkg;

   typedef enum logic [6:0] {
      IDLE        = 7'b000_0001,
      MEPC        = 7'b000_0010,
      MSTATUS     = 7'b000_0100,
      MCAUSE      = 7'b000_1000,
      ASSERT      = 7'b001_0000,
      MRET_ST     = 7'b010_0000,
      MRET_ASSERT = 7'b100_0000
   } state_e;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;

   localparam int CAUSE_ECALL  = 11;
   localparam int CAUSE_EBREAK = 3;

   // Source index width; 5 bits covers the full 1..32 source range.
   localparam int IDX_W = 5;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest-numbered one.
module prio_enc
   import clint_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0]     req,
   output logic             valid,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      idx   = '0;
      valid = |req;
      // Scan downward so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = IDX_W'(i);
      end
   end

endmodule

// File: rtl/clint_mc.sv
// Machine-mode trap sequencer: detects ECALL/EBREAK, enabled interrupts and
// MRET in decode, writes mepc/mstatus/mcause and redirects the pipeline.
module clint_mc
   import clint_pkg::*;
#(
   parameter int NUM_IRQ    = 8,
   parameter int XLEN       = 32,
   parameter int CAUSE_BASE = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IRQ-1:0]  irq_i,
   input  logic [NUM_IRQ-1:0]  irq_en_i,
   input  logic [31:0]         inst_i,
   input  logic                inst_valid_i,
   input  logic [XLEN-1:0]     inst_addr_i,
   input  logic                jump_flag_i,
   input  logic [XLEN-1:0]     jump_addr_i,
   input  logic [XLEN-1:0]     csr_mtvec_i,
   input  logic [XLEN-1:0]     csr_mepc_i,
   input  logic [XLEN-1:0]     csr_mstatus_i,
   output logic                hold_o,
   output logic                csr_we_o,
   output logic [11:0]         csr_waddr_o,
   output logic [XLEN-1:0]     csr_wdata_o,
   output logic                int_assert_o,
   output logic [XLEN-1:0]     int_addr_o,
   output logic [NUM_IRQ-1:0]  irq_claim_o
);

   state_e           state;
   logic [XLEN-1:0]  cause_q;
   logic [XLEN-1:0]  epc_q;
   logic [IDX_W-1:0] idx_q;
   logic             async_q;

   logic [NUM_IRQ-1:0] pending;
   logic               pe_valid;
   logic [IDX_W-1:0]   pe_idx;
   logic               is_ecall, is_ebreak, is_sync, is_async, is_mret, event_taken;

   assign pending = irq_i & irq_en_i;

   prio_enc #(.N(NUM_IRQ)) u_prio_enc (
      .req   (pending),
      .valid (pe_valid),
      .idx   (pe_idx)
   );

   assign is_ecall    = inst_valid_i && (inst_i == INST_ECALL);
   assign is_ebreak   = inst_valid_i && (inst_i == INST_EBREAK);
   assign is_sync     = is_ecall || is_ebreak;
   assign is_async    = inst_valid_i && csr_mstatus_i[3] && pe_valid;
   assign is_mret     = inst_valid_i && (inst_i == INST_MRET);
   assign event_taken = (state == IDLE) && (is_sync || is_async || is_mret);

   // The stall must rise in the detection cycle itself, so it is not registered.
   assign hold_o = !rst && ((state != IDLE) || event_taken);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cause_q <= '0;
         epc_q   <= '0;
         idx_q   <= '0;
         async_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            IDLE: begin
               if (is_sync) begin
                  state   <= MEPC;
                  cause_q <= is_ecall ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_EBREAK);
                  epc_q   <= inst_addr_i;
                  idx_q   <= '0;
                  async_q <= 1'b0;
               end else if (is_async) begin
                  state   <= MEPC;
                  cause_q <= {1'b1, (XLEN-1)'(CAUSE_BASE) + (XLEN-1)'(pe_idx)};
                  epc_q   <= jump_flag_i ? jump_addr_i : inst_addr_i;
                  idx_q   <= pe_idx;
                  async_q <= 1'b1;
               end else if (is_mret) begin
                  state   <= MRET_ST;
               end
            end
            MEPC:        state <= MSTATUS;
            MSTATUS:     state <= MCAUSE;
            MCAUSE:      state <= ASSERT;
            ASSERT:      state <= IDLE;
            MRET_ST:     state <= MRET_ASSERT;
            MRET_ASSERT: state <= IDLE;
            default:     state <= IDLE;
         endcase
      end
   end

   logic [XLEN-1:0] trap_mstatus, mret_mstatus, vec_base, vec_off;

   always_comb begin
      trap_mstatus        = csr_mstatus_i;
      trap_mstatus[7]     = csr_mstatus_i[3];
      trap_mstatus[3]     = 1'b0;
      trap_mstatus[12:11] = 2'b11;

      mret_mstatus        = csr_mstatus_i;
      mret_mstatus[3]     = csr_mstatus_i[7];
      mret_mstatus[7]     = 1'b1;

      vec_base = {csr_mtvec_i[XLEN-1:2], 2'b00};
      vec_off  = (XLEN'(CAUSE_BASE) + XLEN'(idx_q)) << 2;
   end

   always_comb begin
      csr_we_o     = 1'b0;
      csr_waddr_o  = '0;
      csr_wdata_o  = '0;
      int_assert_o = 1'b0;
      int_addr_o   = '0;
      irq_claim_o  = '0;
      case (state)
         MEPC: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MEPC;
            csr_wdata_o = epc_q;
         end
         MSTATUS: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MSTATUS;
            csr_wdata_o = trap_mstatus;
         end
         MCAUSE: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MCAUSE;
            csr_wdata_o = cause_q;
         end
         ASSERT: begin
            int_assert_o = 1'b1;
            // Only interrupts use the vectored slot; exceptions always go to the base.
            int_addr_o   = (csr_mtvec_i[1:0] == 2'b01 && async_q) ? vec_base + vec_off : vec_base;
            if (async_q) irq_claim_o = NUM_IRQ'(1) << idx_q;
         end
         MRET_ST: begin
            csr_we_o    = 1'b1;
            csr_waddr_o = CSR_MSTATUS;
            csr_wdata_o = mret_mstatus;
         end
         MRET_ASSERT: begin
            int_assert_o = 1'b1;
            int_addr_o   = csr_mepc_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_clint_mc.sv
// Scoreboard bench for clint_mc: each scenario queues the CSR writes and
// redirects it expects, and a negedge monitor pops and compares them.
module tb_clint_mc;
   import clint_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  irq, irq_en;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] inst_addr;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic [31:0] csr_mtvec, csr_mepc, csr_mstatus;
   logic        hold_o, csr_we_o, int_assert_o;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o, int_addr_o;
   logic [7:0]  irq_claim_o;

   clint_mc #(.NUM_IRQ(8), .XLEN(32), .CAUSE_BASE(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .irq_i         (irq),
      .irq_en_i      (irq_en),
      .inst_i        (inst),
      .inst_valid_i  (inst_valid),
      .inst_addr_i   (inst_addr),
      .jump_flag_i   (jump_flag),
      .jump_addr_i   (jump_addr),
      .csr_mtvec_i   (csr_mtvec),
      .csr_mepc_i    (csr_mepc),
      .csr_mstatus_i (csr_mstatus),
      .hold_o        (hold_o),
      .csr_we_o      (csr_we_o),
      .csr_waddr_o   (csr_waddr_o),
      .csr_wdata_o   (csr_wdata_o),
      .int_assert_o  (int_assert_o),
      .int_addr_o    (int_addr_o),
      .irq_claim_o   (irq_claim_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        we;
      logic [11:0] waddr;
      logic [31:0] wdata;
      logic        ia;
      logic [31:0] iaddr;
      logic [7:0]  claim;
   } sb_item_t;

   sb_item_t exp_q[$];
   int cyc = 0;
   int checks = 0;
   int failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push_wr(int c, logic [11:0] a, logic [31:0] d);
      sb_item_t it;
      it = '{cyc: c, we: 1'b1, waddr: a, wdata: d, ia: 1'b0, iaddr: '0, claim: '0};
      exp_q.push_back(it);
   endfunction

   function automatic void push_as(int c, logic [31:0] a, logic [7:0] cl);
      sb_item_t it;
      it = '{cyc: c, we: 1'b0, waddr: '0, wdata: '0, ia: 1'b1, iaddr: a, claim: cl};
      exp_q.push_back(it);
   endfunction

   // Monitor: any visible output activity must match the head of the queue.
   always @(negedge clk) begin
      if (!rst && (csr_we_o || int_assert_o || irq_claim_o != 8'h0)) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output cyc=%0d we=%0b waddr=%h wdata=%h ia=%0b iaddr=%h claim=%h (none expected)",
                     cyc, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, irq_claim_o);
         end else begin
            sb_item_t e;
            e = exp_q.pop_front();
            if (cyc != e.cyc || csr_we_o !== e.we || csr_waddr_o !== e.waddr || csr_wdata_o !== e.wdata ||
                int_assert_o !== e.ia || int_addr_o !== e.iaddr || irq_claim_o !== e.claim) begin
               failures++;
               $display("FAIL sb_item got cyc=%0d we=%0b waddr=%h wdata=%h ia=%0b iaddr=%h claim=%h expected cyc=%0d we=%0b waddr=%h wdata=%h ia=%0b iaddr=%h claim=%h",
                        cyc, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o, irq_claim_o,
                        e.cyc, e.we, e.waddr, e.wdata, e.ia, e.iaddr, e.claim);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      irq = '0; irq_en = '0; inst = 32'h13; inst_valid = 1'b0; inst_addr = '0;
      jump_flag = 1'b0; jump_addr = '0; csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      inst = INST_ECALL; inst_valid = 1'b1;   // an event during reset must not raise hold
      step(); step();
      checks++;
      if ({hold_o, csr_we_o, int_assert_o} !== 3'b000) begin
         failures++;
         $display("FAIL reset_ctrl got hold/we/ia=%b expected 000", {hold_o, csr_we_o, int_assert_o});
      end
      checks++;
      if (csr_waddr_o !== 12'h0 || csr_wdata_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_csr got waddr=%h wdata=%h expected 0/0", csr_waddr_o, csr_wdata_o);
      end
      checks++;
      if (int_addr_o !== 32'h0 || irq_claim_o !== 8'h0) begin
         failures++;
         $display("FAIL reset_int got addr=%h claim=%h expected 0/0", int_addr_o, irq_claim_o);
      end
      inst_valid = 1'b0;
      step();
      rst = 1'b0;
      step(); step();
      checks++;
      if (hold_o !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_hold got %b expected 0", hold_o);
      end
   endtask

   task automatic drain(string name);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_drain got %0d outstanding items expected 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic test_ecall();
      int t;
      step(); t = cyc;
      csr_mtvec = 32'h200; csr_mstatus = 32'h8;
      inst = INST_ECALL; inst_addr = 32'h100; inst_valid = 1'b1;
      push_wr(t + 1, CSR_MEPC, 32'h100);
      push_wr(t + 2, CSR_MSTATUS, 32'h1880);
      push_wr(t + 3, CSR_MCAUSE, 32'd11);
      push_as(t + 4, 32'h200, 8'h00);
      for (int k = 0; k <= 5; k++) begin
         if (k > 0) begin step(); inst_valid = 1'b0; end
         #1;
         checks++;
         if (hold_o !== 1'(k <= 4)) begin
            failures++;
            $display("FAIL ecall_hold T+%0d got %b expected %b", k, hold_o, 1'(k <= 4));
         end
      end
      drain("ecall");
   endtask

   task automatic test_vectored_irq();
      int t;
      step(); t = cyc;
      csr_mtvec = 32'h201; csr_mstatus = 32'h8;
      irq = 8'h28; irq_en = 8'h28;
      inst = 32'h13; inst_addr = 32'h400; inst_valid = 1'b1;
      push_wr(t + 1, CSR_MEPC, 32'h400);
      push_wr(t + 2, CSR_MSTATUS, 32'h1880);
      push_wr(t + 3, CSR_MCAUSE, 32'h8000_0013);
      push_as(t + 4, 32'h24C, 8'h08);
      #1;
      checks++;
      if (hold_o !== 1'b1) begin
         failures++;
         $display("FAIL irq_hold_T got %b expected 1", hold_o);
      end
      step();
      irq = 8'h00; inst_valid = 1'b0;   // dropping the request must not abort the sequence
      repeat (5) step();
      drain("vectored_irq");
      irq_en = 8'h00;
   endtask

   task automatic test_masked();
      step();
      csr_mtvec = 32'h201; csr_mstatus = 32'h0;
      irq = 8'h01; irq_en = 8'h01; inst = 32'h13; inst_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k == 3) begin csr_mstatus = 32'h8; irq_en = 8'h00; end
         #1;
         checks++;
         if (hold_o !== 1'b0) begin
            failures++;
            $display("FAIL masked_hold step=%0d got %b expected 0", k, hold_o);
         end
         step();
      end
      inst_valid = 1'b0; irq = 8'h00;
      step();
      drain("masked");
   endtask

   task automatic test_priority();
      int t;
      step(); t = cyc;
      csr_mtvec = 32'h201; csr_mstatus = 32'h8;
      irq = 8'h04; irq_en = 8'h04;
      inst = INST_ECALL; inst_addr = 32'h180; inst_valid = 1'b1;
      push_wr(t + 1, CSR_MEPC, 32'h180);
      push_wr(t + 2, CSR_MSTATUS, 32'h1880);
      push_wr(t + 3, CSR_MCAUSE, 32'd11);
      push_as(t + 4, 32'h200, 8'h00);
      step(); inst_valid = 1'b0;
      repeat (3) step();
      // Back in IDLE at T+5 with the handler's MIE=0: the pending irq waits.
      step();
      csr_mstatus = 32'h0; inst = 32'h13; inst_addr = 32'h184; inst_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (hold_o !== 1'b0) begin
            failures++;
            $display("FAIL prio_wait_hold step=%0d got %b expected 0", k, hold_o);
         end
         step();
      end
      t = cyc;
      csr_mstatus = 32'h8;
      push_wr(t + 1, CSR_MEPC, 32'h184);
      push_wr(t + 2, CSR_MSTATUS, 32'h1880);
      push_wr(t + 3, CSR_MCAUSE, 32'h8000_0012);
      push_as(t + 4, 32'h248, 8'h04);
      step(); inst_valid = 1'b0; irq = 8'h00;
      repeat (5) step();
      drain("priority");
      irq_en = 8'h00;
   endtask

   task automatic test_mret();
      int t;
      step(); t = cyc;
      csr_mstatus = 32'h80; csr_mepc = 32'h104;
      inst = INST_MRET; inst_addr = 32'h110; inst_valid = 1'b1;
      push_wr(t + 1, CSR_MSTATUS, 32'h88);
      push_as(t + 2, 32'h104, 8'h00);
      for (int k = 0; k <= 3; k++) begin
         if (k > 0) begin step(); inst_valid = 1'b0; end
         #1;
         checks++;
         if (hold_o !== 1'(k <= 2)) begin
            failures++;
            $display("FAIL mret_hold T+%0d got %b expected %b", k, hold_o, 1'(k <= 2));
         end
      end
      drain("mret");
   endtask

   task automatic test_back_to_back();
      int t;
      step(); t = cyc;
      csr_mtvec = 32'h204; csr_mstatus = 32'h0;
      inst = INST_EBREAK; inst_addr = 32'h600; inst_valid = 1'b1;
      for (int n = 0; n < 2; n++) begin
         push_wr(t + 5*n + 1, CSR_MEPC, 32'h600);
         push_wr(t + 5*n + 2, CSR_MSTATUS, 32'h1800);
         push_wr(t + 5*n + 3, CSR_MCAUSE, 32'd3);
         push_as(t + 5*n + 4, 32'h204, 8'h00);
      end
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) step();
         if (k == 6) inst_valid = 1'b0;
         #1;
         checks++;
         if (hold_o !== 1'(k <= 9)) begin
            failures++;
            $display("FAIL b2b_hold T+%0d got %b expected %b", k, hold_o, 1'(k <= 9));
         end
      end
      drain("back_to_back");
   endtask

   task automatic test_jump_reset();
      int t;
      step(); t = cyc;
      csr_mtvec = 32'h200; csr_mstatus = 32'h8;
      irq = 8'h01; irq_en = 8'h01;
      inst = 32'h13; inst_addr = 32'h500; inst_valid = 1'b1;
      jump_flag = 1'b1; jump_addr = 32'h300;
      push_wr(t + 1, CSR_MEPC, 32'h300);
      push_wr(t + 2, CSR_MSTATUS, 32'h1880);
      step();
      inst_valid = 1'b0; irq = 8'h00; jump_flag = 1'b0;
      step();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({hold_o, csr_we_o, int_assert_o, irq_claim_o} !== 11'h0 ||
          csr_waddr_o !== 12'h0 || csr_wdata_o !== 32'h0 || int_addr_o !== 32'h0) begin
         failures++;
         $display("FAIL midseq_reset got hold=%b we=%b ia=%b waddr=%h wdata=%h iaddr=%h claim=%h expected all 0",
                  hold_o, csr_we_o, int_assert_o, csr_waddr_o, csr_wdata_o, int_addr_o, irq_claim_o);
      end
      step(); step();
      rst = 1'b0;
      repeat (6) step();
      drain("jump_reset");
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_vectored_irq();
      test_masked();
      test_priority();
      test_mret();
      test_back_to_back();
      test_jump_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clint_mc.md
CLINT_MC -- requirements
Module: clint_mc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, and SHALL name the ports clk and rst.
REQ-002 The block SHALL have parameter NUM_IRQ, default 8: number of external interrupt sources, legal range 1..32.
REQ-003 The block SHALL have parameter XLEN, default 32: data and address width.
REQ-004 The block SHALL have parameter CAUSE_BASE, default 16: the mcause code of source 0.
REQ-005 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- irq_i  in  NUM_IRQ  level interrupt requests
- irq_en_i  in  NUM_IRQ  per-source enable (mie)
- inst_i  in  32  instruction in the decode stage
- inst_valid_i  in  1  inst_i/inst_addr_i are valid
- inst_addr_i  in  XLEN  PC of inst_i
- jump_flag_i  in  1  execute-stage redirect pending
- jump_addr_i  in  XLEN  redirect target
- csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  XLEN  current CSR values
- hold_o  out  1  pipeline stall
- csr_we_o  out  1  CSR write enable
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- int_assert_o  out  1  redirect pulse to execute
- int_addr_o  out  XLEN  redirect target
- irq_claim_o  out  NUM_IRQ  one-hot claim pulse for the taken source

Function
REQ-006 The state machine SHALL use these one-hot states: IDLE, MEPC, MSTATUS, MCAUSE, ASSERT, MRET_ST, MRET_ASSERT; all outputs except hold_o SHALL be Moore decodes of the state register.
REQ-007 Event detection in IDLE SHALL apply only when inst_valid_i=1, with priority sync exception > async interrupt > mret.
- Sync exception: inst_i is ECALL (cause 11) or EBREAK (cause 3).
- Async interrupt: mstatus[3]=1 and (irq_i & irq_en_i) != 0.
- Mret: inst_i is MRET.
REQ-008 Among pending async sources, the lowest index SHALL win; cause = {1'b1, (CAUSE_BASE+idx) in XLEN-1 bits}.
REQ-009 On taking an event at the edge ending cycle T, the block SHALL latch cause, epc, the winning index and an is_async flag.
- epc for sync = inst_addr_i.
- epc for async = jump_addr_i if jump_flag_i, else inst_addr_i.
REQ-010 The trap sequence SHALL be IDLE -> MEPC (T+1) -> MSTATUS (T+2) -> MCAUSE (T+3) -> ASSERT (T+4) -> IDLE.
REQ-011 In MEPC the block SHALL drive we=1, waddr=0x341, wdata=epc.
REQ-012 In MSTATUS the block SHALL drive we=1, waddr=0x300, wdata = mstatus with MPIE[7] <= MIE[3], MIE <= 0, MPP[12:11] <= 2'b11.
REQ-013 In MCAUSE the block SHALL drive we=1, waddr=0x342, wdata=cause.
REQ-014 In ASSERT the block SHALL drive int_assert_o=1 and int_addr_o as follows, with mtvec sampled in ASSERT:
- If mtvec[1:0]==2'b01 and is_async: {mtvec[XLEN-1:2],2'b00} + 4*(CAUSE_BASE+idx).
- Otherwise: {mtvec[XLEN-1:2],2'b00}.
REQ-015 In ASSERT the block SHALL pulse irq_claim_o[idx] for one cycle when is_async; irq_claim_o SHALL be zero otherwise.
REQ-016 The mret sequence SHALL be IDLE -> MRET_ST (T+1) -> MRET_ASSERT (T+2) -> IDLE.
- MRET_ST: we=1, waddr=0x300, wdata = mstatus with MIE <= MPIE, MPIE <= 1.
- MRET_ASSERT: int_assert_o=1, int_addr_o=csr_mepc_i.
REQ-017 In all other states csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o and irq_claim_o SHALL be 0.
REQ-018 hold_o SHALL equal (state != IDLE) | event_taken_this_cycle (combinational), so the stall asserts in cycle T.
REQ-019 Events arriving while state != IDLE SHALL be ignored; a level irq still pending on return to IDLE SHALL be re-evaluated against the updated mstatus.
REQ-020 An irq deasserting mid-sequence SHALL NOT abort the sequence; the latched cause SHALL be used.

Reset
REQ-021 On rst=1, asynchronously: state=IDLE, and latched cause, epc, idx and is_async cleared to 0.
REQ-022 On rst=1, asynchronously: all outputs 0, hold_o=0.
REQ-023 Reset asserted mid-sequence SHALL abandon the sequence with no further CSR write.

Structure
REQ-024 Package clint_pkg SHALL hold the state encoding, the CSR addresses (MSTATUS 0x300, MEPC 0x341, MCAUSE 0x342) and the ECALL/EBREAK/MRET encodings.
REQ-025 Sub-module prio_enc (NUM_IRQ-wide, lowest index wins, outputs valid + index) SHALL perform source selection.

Verification
REQ-026 Scenario: ECALL at PC 0x100, mtvec 0x200 -> MEPC write 0x100 at T+1, mcause 11 at T+3, int_addr 0x200 at T+4, hold_o high T..T+4.
REQ-027 Scenario: irq 3 and 5 with both enabled, MIE=1, CAUSE_BASE 16, vectored mtvec 0x201 -> mcause 0x80000013, int_addr 0x24C, irq_claim_o=0x08.
REQ-028 Scenario: irq with MIE=0, or irq_en_i=0 -> no sequence, hold_o=0.
REQ-029 Scenario: ECALL with irq pending -> sync taken (cause 11); irq taken after return once MIE=1.
REQ-030 Scenario: MRET with mstatus 0x80, mepc 0x104 -> mstatus write 0x88 at T+1, int_addr 0x104 at T+2.
REQ-031 Scenario: async irq with jump_flag_i=1, jump_addr 0x300 -> mepc 0x300; rst asserted at MSTATUS -> outputs 0 immediately, no MCAUSE write.
